// File: rtl/arb_burst_ctrl_pkg.sv
// Shared definitions for the burst front-end: slot state encoding,
// requester count and a lowest-set-bit helper used by the bus mux.
package arb_burst_ctrl_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_REL  = 2'd2
    } slot_state_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [1:0] lowest_set_idx(input logic [3:0] vec);
        logic [1:0] idx;
        idx = 2'd0;
        if (vec[0]) begin
            idx = 2'd0;
        end else if (vec[1]) begin
            idx = 2'd1;
        end else if (vec[2]) begin
            idx = 2'd2;
        end else if (vec[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_burst_slot.sv
// One requester: accepts a burst command, holds its request while beats
// remain, then releases the request for one cycle before going idle.
module arb_burst_slot
    import arb_burst_ctrl_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             take,
    output logic             cmd_ready,
    output logic             req,
    output logic             busy,
    output logic             last,
    output logic             beat_ack,
    output logic             done
);

    localparam logic [LEN_W-1:0] REM_ZERO = '0;
    localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);

    slot_state_e      state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             fire_s;

    // Next state, remaining-beat count and completion pulse.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        fire_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == REM_ZERO) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = cmd_len;
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // rem never wraps: a beat only counts while something remains
                if (take && (rem_q != REM_ZERO)) begin
                    fire_s = 1'b1;
                    rem_d  = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_REL;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_REL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= REM_ZERO;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign req       = (state_q == ST_BUSY);
    assign busy      = (state_q == ST_BUSY);
    assign last      = (state_q == ST_BUSY) && (rem_q == REM_ONE);
    assign beat_ack  = fire_s;
    assign done      = done_q;

endmodule

// File: rtl/arb_burst_ctrl.sv
// Burst front-end for a 4-way arbiter: four request slots, a grant-driven
// mux onto one shared bus, and a sticky flag for multiple simultaneous grants.
module arb_burst_ctrl
    import arb_burst_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            cmd_valid,
    output logic [3:0]            cmd_ready,
    input  logic [4*LEN_W-1:0]    cmd_len,
    input  logic [4*DATA_W-1:0]   m_data,
    output logic [3:0]            m_beat_ack,
    output logic [3:0]            done,
    output logic                  req3,
    output logic                  req2,
    output logic                  req1,
    output logic                  req0,
    input  logic                  gnt3,
    input  logic                  gnt2,
    input  logic                  gnt1,
    input  logic                  gnt0,
    output logic                  bus_valid,
    output logic [DATA_W-1:0]     bus_data,
    output logic [1:0]            bus_src,
    output logic                  bus_last,
    input  logic                  bus_ready,
    output logic                  gnt_err
);

    logic [3:0] gnt_s;
    logic [3:0] req_s;
    logic [3:0] busy_s;
    logic [3:0] last_s;
    logic [3:0] act_s;
    logic [3:0] take_s;
    logic [1:0] idx_s;
    logic       multi_gnt_s;
    logic       gnt_err_q, gnt_err_d;

    assign gnt_s = {gnt3, gnt2, gnt1, gnt0};
    assign req3  = req_s[3];
    assign req2  = req_s[2];
    assign req1  = req_s[1];
    assign req0  = req_s[0];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        arb_burst_slot #(
            .LEN_W(LEN_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .cmd_valid(cmd_valid[i]),
            .cmd_len  (cmd_len[i*LEN_W +: LEN_W]),
            .take     (take_s[i]),
            .cmd_ready(cmd_ready[i]),
            .req      (req_s[i]),
            .busy     (busy_s[i]),
            .last     (last_s[i]),
            .beat_ack (m_beat_ack[i]),
            .done     (done[i])
        );
    end

    // Shared bus mux: lowest-index busy+granted slot drives the bus and alone may take a beat.
    always_comb begin
        act_s     = busy_s & gnt_s;
        idx_s     = lowest_set_idx(act_s);
        bus_valid = |act_s;
        take_s    = 4'b0000;
        bus_data  = '0;
        bus_src   = 2'd0;
        bus_last  = 1'b0;
        if (bus_valid) begin
            take_s[idx_s] = bus_ready;
            bus_data      = m_data[idx_s*DATA_W +: DATA_W];
            bus_src       = idx_s;
            bus_last      = last_s[idx_s];
        end else begin
            take_s   = 4'b0000;
            bus_data = '0;
            bus_src  = 2'd0;
            bus_last = 1'b0;
        end
    end

    // Sticky grant-error flag: set on two or more grant lines high at once.
    always_comb begin
        multi_gnt_s = ((gnt_s & (gnt_s - 4'd1)) != 4'd0);
        gnt_err_d   = gnt_err_q | multi_gnt_s;
    end

    // Grant-error register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_err_q <= 1'b0;
        end else begin
            gnt_err_q <= gnt_err_d;
        end
    end

    assign gnt_err = gnt_err_q;

endmodule
